// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 2-cycle ALU: valid/ready intake, per-class dv strobes,
// register/load hazard scoreboards, branch freeze with flush pulse.
// Latency: issue is combinational; scoreboard, FSM and stall counter are registered.
module alu_issue_ctrl #(
  parameter int pLoadMax = 4,  // maximum outstanding loads (1..15)
  parameter int pRegLat  = 3   // cycles until a reg-op result is readable
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iInstValid,
  output logic        oInstReady,
  input  logic [1:0]  iOpClass,
  input  logic [4:0]  iRs1Addr,
  input  logic [4:0]  iRs2Addr,
  input  logic [4:0]  iRdAddr,
  input  logic        iUsesRs1,
  input  logic        iUsesRs2,
  output logic        oIssueReg,
  output logic        oIssueMem,
  output logic        oIssueBranch,
  input  logic        iBranchTaken,
  input  logic        iLoadDone,
  input  logic [4:0]  iLoadDoneAddr,
  output logic        oFlush,
  output logic [15:0] oStallCycles
);

  localparam logic [1:0] OP_REG    = 2'd0;
  localparam logic [1:0] OP_LOAD   = 2'd1;
  localparam logic [1:0] OP_STORE  = 2'd2;
  localparam logic [1:0] OP_BRANCH = 2'd3;
  localparam logic [3:0] LOAD_MAX  = 4'(pLoadMax);

  typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;

  state_t      state_q;
  logic        br_cnt_q;      // branch wait counter, loaded with 1 on branch issue
  logic        flush_q;

  logic [pRegLat-1:0] pipe_vld_q;
  logic [4:0]         pipe_rd_q [pRegLat];

  logic [31:0] pend_q, pend_d;
  logic [3:0]  lcnt_q, lcnt_d;
  logic [15:0] stall_q;

  logic [31:0] busy_vec;
  logic        is_load, hazard, fire, ld_fire, reg_fire_nz;

  // Registers that cannot be read yet: in-flight reg results plus pending loads; x0 is never busy
  always_comb begin
    busy_vec = pend_q;
    for (int i = 0; i < pRegLat; i++) begin
      if (pipe_vld_q[i]) busy_vec[pipe_rd_q[i]] = 1'b1;
    end
    busy_vec[0] = 1'b0;
  end

  // Hazard detection, handshake and per-class strobes
  always_comb begin
    is_load     = (iOpClass == OP_LOAD);
    hazard      = (iUsesRs1 && busy_vec[iRs1Addr]) ||
                  (iUsesRs2 && busy_vec[iRs2Addr]) ||
                  (is_load && ((lcnt_q == LOAD_MAX) || pend_q[iRdAddr]));
    oInstReady  = (state_q == RUN) && !hazard;
    fire        = iInstValid && oInstReady;
    ld_fire     = fire && is_load;
    reg_fire_nz = fire && (iOpClass == OP_REG) && (iRdAddr != 5'd0);
    oIssueReg    = fire && (iOpClass == OP_REG);
    oIssueMem    = fire && (is_load || (iOpClass == OP_STORE));
    oIssueBranch = fire && (iOpClass == OP_BRANCH);
  end

  // Next load-scoreboard state: a same-cycle set beats the completion clear
  always_comb begin
    pend_d = pend_q;
    if (iLoadDone) pend_d[iLoadDoneAddr] = 1'b0;
    if (ld_fire && (iRdAddr != 5'd0)) pend_d[iRdAddr] = 1'b1;
    pend_d[0] = 1'b0;
    lcnt_d = lcnt_q;
    case ({ld_fire, iLoadDone})
      2'b10:   lcnt_d = lcnt_q + 4'd1;
      2'b01:   if (lcnt_q != 4'd0) lcnt_d = lcnt_q - 4'd1;  // late completion after reset
      default: lcnt_d = lcnt_q;
    endcase
  end

  // Reg-result shift pipe, advances every cycle regardless of stalls
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < pRegLat; i++) pipe_rd_q[i] <= 5'd0;
    end else begin
      for (int i = pRegLat - 1; i > 0; i--) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_rd_q[i]  <= pipe_rd_q[i-1];
      end
      pipe_vld_q[0] <= reg_fire_nz;
      pipe_rd_q[0]  <= iRdAddr;
    end
  end

  // Load scoreboard registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pend_q <= '0;
      lcnt_q <= 4'd0;
    end else begin
      pend_q <= pend_d;
      lcnt_q <= lcnt_d;
    end
  end

  // Branch FSM: freeze issue until the ALU resolves, then flush one cycle if taken
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= RUN;
      br_cnt_q <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (oIssueBranch) begin
            state_q  <= BR_WAIT;
            br_cnt_q <= 1'b1;
          end
        end
        BR_WAIT: begin
          if (br_cnt_q == 1'b0) begin
            if (iBranchTaken) begin
              state_q <= FLUSH;
              flush_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end else begin
            br_cnt_q <= br_cnt_q - 1'b1;
          end
        end
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating count of cycles where the decoder was held off
  always_ff @(posedge iClk) begin
    if (iRst) begin
      stall_q <= 16'd0;
    end else if (iInstValid && !oInstReady && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign oFlush       = flush_q;
  assign oStallCycles = stall_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table, hand-timed corner sequences,
// and randomized traffic checked every cycle against a ready-time reference model.
module tb_alu_issue_ctrl;
  localparam int LMAX = 4;
  localparam int RLAT = 3;

  logic        iClk = 1'b0;
  logic        iRst, iInstValid, oInstReady;
  logic [1:0]  iOpClass;
  logic [4:0]  iRs1Addr, iRs2Addr, iRdAddr, iLoadDoneAddr;
  logic        iUsesRs1, iUsesRs2, iBranchTaken, iLoadDone;
  logic        oIssueReg, oIssueMem, oIssueBranch, oFlush;
  logic [15:0] oStallCycles;

  int n_chk  = 0;
  int n_pass = 0;

  alu_issue_ctrl #(.pLoadMax(LMAX), .pRegLat(RLAT)) dut (
    .iClk(iClk), .iRst(iRst), .iInstValid(iInstValid), .oInstReady(oInstReady),
    .iOpClass(iOpClass), .iRs1Addr(iRs1Addr), .iRs2Addr(iRs2Addr), .iRdAddr(iRdAddr),
    .iUsesRs1(iUsesRs1), .iUsesRs2(iUsesRs2), .oIssueReg(oIssueReg), .oIssueMem(oIssueMem),
    .oIssueBranch(oIssueBranch), .iBranchTaken(iBranchTaken), .iLoadDone(iLoadDone),
    .iLoadDoneAddr(iLoadDoneAddr), .oFlush(oFlush), .oStallCycles(oStallCycles)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model: per-register ready times ----------------
  int cyc = 0;
  int reg_rdy [32];   // first cycle a reg-op result may be read
  bit pend    [32];   // load outstanding for this register
  int lcnt, issue_ok, flush_at, br_at, stall_m;
  bit en = 1'b0;

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 5'd0) && ((reg_rdy[r] > cyc) || pend[r]);
  endfunction

  function automatic bit m_ready();
    if (cyc < issue_ok || cyc == flush_at) return 1'b0;
    if (iUsesRs1 && m_busy(iRs1Addr)) return 1'b0;
    if (iUsesRs2 && m_busy(iRs2Addr)) return 1'b0;
    if (iOpClass == 2'd1 && (lcnt == LMAX || (iRdAddr != 5'd0 && pend[iRdAddr]))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      reg_rdy[i] = 0;
      pend[i]    = 1'b0;
    end
    lcnt = 0; issue_ok = 0; flush_at = -1; br_at = -1; stall_m = 0;
  endtask

  always @(posedge iClk) begin
    bit r, f;
    if (iRst) begin
      m_reset();
      en = 1'b1;
    end else if (en) begin
      r = m_ready();
      f = iInstValid && r;
      if (iInstValid && !r && stall_m < 65535) stall_m++;
      if (cyc == br_at) begin
        if (iBranchTaken) begin
          flush_at = cyc + 1;
          issue_ok = cyc + 2;
        end else begin
          issue_ok = cyc + 1;
        end
      end
      if (f && iOpClass == 2'd3) begin
        br_at    = cyc + 2;
        issue_ok = cyc + 3;
      end
      if (f && iOpClass == 2'd0 && iRdAddr != 5'd0 && reg_rdy[iRdAddr] < cyc + RLAT + 1)
        reg_rdy[iRdAddr] = cyc + RLAT + 1;
      if (iLoadDone) pend[iLoadDoneAddr] = 1'b0;
      if (f && iOpClass == 2'd1 && iRdAddr != 5'd0) pend[iRdAddr] = 1'b1;
      if (f && iOpClass == 2'd1 && !iLoadDone) lcnt++;
      else if (iLoadDone && !(f && iOpClass == 2'd1) && lcnt > 0) lcnt--;
    end
    cyc++;
  end

  always @(negedge iClk) begin
    bit r, f;
    if (en) begin
      r = m_ready();
      f = iInstValid && r;
      chk("m_ready",  32'(oInstReady),   32'(r));
      chk("m_reg",    32'(oIssueReg),    32'(f && iOpClass == 2'd0));
      chk("m_mem",    32'(oIssueMem),    32'(f && (iOpClass == 2'd1 || iOpClass == 2'd2)));
      chk("m_branch", 32'(oIssueBranch), 32'(f && iOpClass == 2'd3));
      chk("m_flush",  32'(oFlush),       32'(cyc == flush_at));
      chk("m_stall",  32'(oStallCycles), 32'(stall_m));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic set_inst(input logic v, input logic [1:0] c, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [4:0] d,
                          input logic u1, input logic u2);
    iInstValid = v; iOpClass = c; iRs1Addr = s1; iRs2Addr = s2; iRdAddr = d;
    iUsesRs1 = u1; iUsesRs2 = u2;
  endtask

  task automatic idle();
    set_inst(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    iBranchTaken = 1'b0; iLoadDone = 1'b0; iLoadDoneAddr = 5'd0;
  endtask

  task automatic do_reset();
    idle();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
  endtask

  // Present an instruction and hold it until accepted; returns cycles stalled
  task automatic issue(input logic [1:0] c, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic u1, input logic u2, output int waited);
    set_inst(1'b1, c, s1, s2, d, u1, u2);
    waited = 0;
    forever begin
      @(negedge iClk);
      if (oInstReady === 1'b1) break;
      waited++;
      if (waited > 40) begin
        n_chk++;
        $display("FAIL issue_timeout: oInstReady still low after %0d cycles, required within 40", waited);
        break;
      end
    end
    tick();
    iInstValid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [1:0] c;
    logic [4:0] s1, s2, d;
    logic       u1, u2, tk;
    logic       e_rdy, e_reg, e_mem, e_br;
  } vec_t;

  vec_t tbl [13];
  int   w;

  initial begin
    iRst = 1'b1;
    idle();
    //           v   c   s1  s2  d   u1 u2 tk  rdy reg mem br
    tbl[0]  = '{1, 0,  0,  0,  5,  0, 0, 0,  1,  1,  0,  0};  // x5 = ...
    tbl[1]  = '{1, 0,  5,  0,  0,  1, 0, 0,  0,  0,  0,  0};  // reads x5 in flight
    tbl[2]  = '{1, 2,  0,  5,  0,  1, 0, 0,  1,  0,  1,  0};  // rs2=x5 unused, rs1=x0
    tbl[3]  = '{1, 1,  0,  0,  6,  1, 0, 0,  1,  0,  1,  0};  // load x6
    tbl[4]  = '{1, 0,  0,  6,  0,  0, 1, 0,  0,  0,  0,  0};  // reads pending x6
    tbl[5]  = '{1, 0,  5,  0,  0,  1, 0, 0,  1,  1,  0,  0};  // x5 readable again
    tbl[6]  = '{1, 1,  0,  0,  6,  0, 0, 0,  0,  0,  0,  0};  // WAW on x6
    tbl[7]  = '{0, 0,  0,  0,  0,  0, 0, 0,  1,  0,  0,  0};  // no valid, no strobe
    tbl[8]  = '{1, 3,  0,  0,  0,  0, 0, 0,  1,  0,  0,  1};  // branch
    tbl[9]  = '{1, 0,  0,  0,  1,  0, 0, 0,  0,  0,  0,  0};  // frozen
    tbl[10] = '{1, 0,  0,  0,  1,  0, 0, 0,  0,  0,  0,  0};  // frozen, not taken
    tbl[11] = '{1, 0,  0,  0,  1,  0, 0, 0,  1,  1,  0,  0};  // resumes
    tbl[12] = '{1, 1,  0,  0,  6,  0, 0, 0,  0,  0,  0,  0};  // x6 still pending
    tick();
    do_reset();
    @(negedge iClk);
    chk("rst_ready", 32'(oInstReady), 32'd1);
    chk("rst_flush", 32'(oFlush), 32'd0);
    chk("rst_stall", 32'(oStallCycles), 32'd0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_inst(tbl[i].v, tbl[i].c, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].u1, tbl[i].u2);
      iBranchTaken = tbl[i].tk;
      @(negedge iClk);
      chk($sformatf("vec%0d_ready", i),  32'(oInstReady),   32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_reg", i),    32'(oIssueReg),    32'(tbl[i].e_reg));
      chk($sformatf("vec%0d_mem", i),    32'(oIssueMem),    32'(tbl[i].e_mem));
      chk($sformatf("vec%0d_branch", i), 32'(oIssueBranch), 32'(tbl[i].e_br));
      tick();
    end
    idle();

    // back-to-back independent reg ops
    do_reset();
    issue(2'd0, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, w); chk("b2b_first_wait", 32'(w), 32'd0);
    issue(2'd0, 5'd5, 5'd6, 5'd4, 1'b1, 1'b1, w); chk("b2b_second_wait", 32'(w), 32'd0);

    // reg-op RAW: stalls pRegLat cycles
    do_reset();
    issue(2'd0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, w);
    issue(2'd0, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, w); chk("raw_wait", 32'(w), 32'd3);
    @(negedge iClk);
    chk("raw_stall_count", 32'(oStallCycles), 32'd3);
    tick();

    // load limit: fifth load waits for a completion, not bypassed
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      issue(2'd1, 5'd0, 5'd0, 5'(i), 1'b0, 1'b0, w);
      chk($sformatf("load%0d_wait", i), 32'(w), 32'd0);
    end
    set_inst(1'b1, 2'd1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge iClk); chk("ld_full_stall", 32'(oInstReady), 32'd0); tick();
    end
    iLoadDone = 1'b1; iLoadDoneAddr = 5'd1;
    @(negedge iClk); chk("ld_full_done_cycle", 32'(oInstReady), 32'd0); tick();
    iLoadDone = 1'b0;
    @(negedge iClk); chk("ld_full_after_done", 32'(oInstReady), 32'd1); tick();
    idle();

    // store reading a pending load target
    do_reset();
    issue(2'd1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, w);
    set_inst(1'b1, 2'd2, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge iClk); chk("st_pending_stall", 32'(oInstReady), 32'd0); tick();
    end
    iLoadDone = 1'b1; iLoadDoneAddr = 5'd1;
    @(negedge iClk); chk("st_done_cycle", 32'(oInstReady), 32'd0); tick();
    iLoadDone = 1'b0;
    @(negedge iClk); chk("st_after_done", 32'(oInstReady), 32'd1);
    chk("st_mem_strobe", 32'(oIssueMem), 32'd1); tick();
    idle();

    // taken branch: flush in T+3 only, next issue T+4
    do_reset();
    issue(2'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, w);
    set_inst(1'b1, 2'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    @(negedge iClk); chk("bt_t1_ready", 32'(oInstReady), 32'd0); chk("bt_t1_flush", 32'(oFlush), 32'd0); tick();
    iBranchTaken = 1'b1;
    @(negedge iClk); chk("bt_t2_ready", 32'(oInstReady), 32'd0); tick();
    iBranchTaken = 1'b0;
    @(negedge iClk); chk("bt_t3_flush", 32'(oFlush), 32'd1); chk("bt_t3_ready", 32'(oInstReady), 32'd0); tick();
    @(negedge iClk); chk("bt_t4_flush", 32'(oFlush), 32'd0); chk("bt_t4_ready", 32'(oInstReady), 32'd1); tick();
    idle();

    // not-taken branch: taken bit outside T+2 is ignored, next issue T+3
    issue(2'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, w);
    set_inst(1'b1, 2'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    iBranchTaken = 1'b1;
    @(negedge iClk); chk("bn_t1_ready", 32'(oInstReady), 32'd0); tick();
    iBranchTaken = 1'b0;
    @(negedge iClk); chk("bn_t2_ready", 32'(oInstReady), 32'd0); tick();
    iBranchTaken = 1'b1;
    @(negedge iClk); chk("bn_t3_ready", 32'(oInstReady), 32'd1); chk("bn_t3_flush", 32'(oFlush), 32'd0); tick();
    @(negedge iClk); chk("bn_t4_flush", 32'(oFlush), 32'd0); tick();
    idle();

    // x0 never marked; same-cycle completion and new load to x9 keeps x9 pending
    do_reset();
    issue(2'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, w);
    issue(2'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, w); chk("x0_no_stall", 32'(w), 32'd0);
    iLoadDone = 1'b1; iLoadDoneAddr = 5'd9;
    issue(2'd1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, w); chk("x9_load_wait", 32'(w), 32'd0);
    iLoadDone = 1'b0;
    set_inst(1'b1, 2'd0, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk); chk("x9_still_pending", 32'(oInstReady), 32'd0); tick();
    end
    idle();

    // reset while frozen with loads outstanding; late completion must not underflow
    do_reset();
    issue(2'd1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, w);
    issue(2'd1, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, w);
    issue(2'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, w);
    iRst = 1'b1; tick(); iRst = 1'b0;
    set_inst(1'b0, 2'd1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    iLoadDone = 1'b1; iLoadDoneAddr = 5'd2;
    @(negedge iClk);
    chk("rstbr_ready", 32'(oInstReady), 32'd1);
    chk("rstbr_stall", 32'(oStallCycles), 32'd0);
    chk("rstbr_flush", 32'(oFlush), 32'd0);
    tick();
    iLoadDone = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      issue(2'd1, 5'd0, 5'd0, 5'(i), 1'b0, 1'b0, w);
      chk($sformatf("rstbr_load%0d_wait", i), 32'(w), 32'd0);
    end
    set_inst(1'b1, 2'd1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
    @(negedge iClk); chk("rstbr_fifth_load_stall", 32'(oInstReady), 32'd0); tick();
    idle();

    // randomized traffic on a small register window, checked by the model each cycle
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      iRst          = ($urandom_range(0, 99) == 0);
      iInstValid    = ($urandom_range(0, 9) < 7);
      iOpClass      = 2'($urandom_range(0, 3));
      iRs1Addr      = 5'($urandom_range(0, 7));
      iRs2Addr      = 5'($urandom_range(0, 7));
      iRdAddr       = 5'($urandom_range(0, 7));
      iUsesRs1      = 1'($urandom_range(0, 1));
      iUsesRs2      = 1'($urandom_range(0, 1));
      iBranchTaken  = 1'($urandom_range(0, 1));
      iLoadDone     = ($urandom_range(0, 9) < 3);
      iLoadDoneAddr = 5'($urandom_range(0, 7));
      tick();
    end
    iRst = 1'b0;
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
